// File: rtl/tbec_pkg.sv
// Shared types and constants for the TBEC background scrubber.
package tbec_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    CHECK,
    WRITE,
    NEXT,
    HOST
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_CORR   = 2'b01;
  localparam logic [1:0] ERR_UNCORR = 2'b10;
  localparam logic [1:0] ERR_RSVD   = 2'b11;

endpackage

// File: rtl/tbec_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module tbec_sat_cnt
  import tbec_pkg::*;
(
  input  logic             tbec_clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge tbec_clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/tbec_scrubber.sv
// Background memory scrubber: walks every address, writes back corrected words,
// logs uncorrectable ones, and yields the memory path to the host between scrubs.
module tbec_scrubber
  import tbec_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = 2,
  parameter int WR_HOLD = 2
) (
  input  logic              tbec_clk,
  input  logic              rst,
  input  logic              scrub_en,
  input  logic [15:0]       interval,
  input  logic              host_req,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [1:0]        mem_err,
  output logic [15:0]       corr_cnt,
  output logic [15:0]       uncorr_cnt,
  output logic [ADDR_W-1:0] last_uncorr_addr,
  output logic              pass_done,
  output logic              busy
);

  localparam logic [15:0] RD_LOAD = 16'(RD_LAT - 1);
  localparam logic [15:0] WR_LOAD = 16'(WR_HOLD - 1);

  state_t            state_reg, state_next;
  logic [15:0]       tmr_reg, tmr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] uaddr_reg, uaddr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              pass_reg, pass_next;
  logic              corr_inc, uncorr_inc;

  always_ff @(posedge tbec_clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tmr_reg   <= '0;
      addr_reg  <= '0;
      uaddr_reg <= '0;
      data_reg  <= '0;
      pass_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
      addr_reg  <= addr_next;
      uaddr_reg <= uaddr_next;
      data_reg  <= data_next;
      pass_reg  <= pass_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    addr_next  = addr_reg;
    uaddr_next = uaddr_reg;
    data_next  = data_reg;
    pass_next  = 1'b0;
    corr_inc   = 1'b0;
    uncorr_inc = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host_req) begin
          state_next = HOST;
        end else if (scrub_en) begin
          state_next = WAIT;
          tmr_next   = interval;
        end
      end
      // A load of N gives N idle cycles; 0 and 1 both leave after one cycle.
      WAIT: begin
        if (host_req) begin
          state_next = HOST;
        end else if (!scrub_en) begin
          state_next = IDLE;
        end else if (tmr_reg <= 16'd1) begin
          state_next = READ;
          tmr_next   = RD_LOAD;
        end else begin
          tmr_next = tmr_reg - 16'd1;
        end
      end
      READ: begin
        if (tmr_reg == 16'd0) begin
          state_next = CHECK;
        end else begin
          tmr_next = tmr_reg - 16'd1;
        end
      end
      CHECK: begin
        case (mem_err)
          ERR_NONE: state_next = NEXT;
          ERR_CORR: begin
            corr_inc   = 1'b1;
            data_next  = mem_rd_data;
            tmr_next   = WR_LOAD;
            state_next = WRITE;
          end
          ERR_UNCORR, ERR_RSVD: begin
            uncorr_inc = 1'b1;
            uaddr_next = addr_reg;
            state_next = NEXT;
          end
        endcase
      end
      WRITE: begin
        if (tmr_reg == 16'd0) begin
          state_next = NEXT;
        end else begin
          tmr_next = tmr_reg - 16'd1;
        end
      end
      NEXT: begin
        addr_next = addr_reg + 1'b1;
        pass_next = &addr_reg;
        if (scrub_en) begin
          state_next = WAIT;
          tmr_next   = interval;
        end else begin
          state_next = IDLE;
        end
      end
      HOST: begin
        if (!host_req) begin
          if (scrub_en) begin
            state_next = WAIT;
            tmr_next   = interval;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  tbec_sat_cnt u_corr_cnt (
    .tbec_clk (tbec_clk),
    .rst      (rst),
    .inc      (corr_inc),
    .cnt      (corr_cnt)
  );

  tbec_sat_cnt u_uncorr_cnt (
    .tbec_clk (tbec_clk),
    .rst      (rst),
    .inc      (uncorr_inc),
    .cnt      (uncorr_cnt)
  );

  // Grant is visible in the same cycle the request is accepted in IDLE/WAIT.
  assign host_gnt = !rst && ((state_reg == HOST) ||
                    (host_req && ((state_reg == IDLE) || (state_reg == WAIT))));

  assign mem_we           = (state_reg == WRITE);
  assign busy             = (state_reg != IDLE);
  assign mem_addr         = addr_reg;
  assign mem_data         = data_reg;
  assign last_uncorr_addr = uaddr_reg;
  assign pass_done        = pass_reg;

endmodule

// File: doc/tbec_scrubber.md
TBEC_SCRUBBER -- requirements
Module: tbec_scrubber

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, decoded data width.
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from address issue to valid mem_rd_data/mem_err.
REQ-004 SHALL have parameter WR_HOLD, default 2, cycles that address, data and mem_we are held for one write-back.
REQ-005 SHALL have port tbec_clk, input, 1, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port scrub_en, input, 1, enables background scrubbing.
REQ-008 SHALL have port interval, input, 16, idle cycles between consecutive address scrubs.
REQ-009 SHALL have port host_req, input, 1, host requests the memory path.
REQ-010 SHALL have port host_gnt, output, 1, host owns the memory path.
REQ-011 SHALL have port mem_addr, output, ADDR_W, scrub address to the encode/memory/decode path.
REQ-012 SHALL have port mem_data, output, DATA_W, corrected write-back data.
REQ-013 SHALL have port mem_we, output, 1, write-back enable.
REQ-014 SHALL have port mem_rd_data, input, DATA_W, decoded read data.
REQ-015 SHALL have port mem_err, input, 2, decoder status: 00 clean, 01 corrected, 10 uncorrectable, 11 reserved (treated as 10).
REQ-016 SHALL have ports corr_cnt and uncorr_cnt, output, 16 each, saturating event counters.
REQ-017 SHALL have port last_uncorr_addr, output, ADDR_W, address of the most recent uncorrectable word.
REQ-018 SHALL have ports pass_done, output, 1 (one-cycle pulse when a full address pass completes), and busy, output, 1 (high when not IDLE).

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, READ, CHECK, WRITE, NEXT, HOST.
REQ-020 IDLE -> WAIT when scrub_en=1, loading the interval counter with interval; IDLE -> HOST when host_req=1 (host wins when both are high).
REQ-021 WAIT decrements the counter and goes to READ when counter=0; interval=0 SHALL go to READ on the next cycle.
REQ-022 WAIT -> HOST when host_req=1; WAIT -> IDLE when scrub_en=0.
REQ-023 host_req SHALL be sampled only in IDLE and WAIT; READ, CHECK, WRITE and NEXT are never interrupted.
REQ-024 HOST drives host_gnt=1 and mem_we=0, and exits to WAIT with the interval reloaded (or to IDLE if scrub_en=0) one cycle after host_req=0.
REQ-025 READ holds mem_addr stable for exactly RD_LAT cycles, then enters CHECK.
REQ-026 CHECK samples mem_err and mem_rd_data in one cycle, as follows:
- 00 -> NEXT.
- 01 -> increment corr_cnt, latch the data into mem_data, go to WRITE.
- 10/11 -> increment uncorr_cnt, load last_uncorr_addr with mem_addr, go to NEXT with no write.
REQ-027 WRITE asserts mem_we for exactly WR_HOLD consecutive cycles, with mem_addr and mem_data stable, then enters NEXT.
REQ-028 NEXT increments mem_addr modulo 2^ADDR_W; on wrap from all-ones to 0 it pulses pass_done for one cycle. It then goes to WAIT with the interval reloaded, or to IDLE if scrub_en=0.
REQ-029 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-030 Deasserting scrub_en mid-scrub SHALL let the current address finish through NEXT before going to IDLE.
REQ-031 mem_we SHALL be 0 in every state except WRITE.

Reset
REQ-032 While rst=1 the FSM SHALL enter IDLE, with these output values:
- mem_addr=0, mem_data=0, mem_we=0, host_gnt=0.
- corr_cnt=0, uncorr_cnt=0, last_uncorr_addr=0.
- pass_done=0, busy=0.
REQ-033 rst SHALL override any state, including a WRITE in progress, with mem_we=0 in the following cycle.

Structure
REQ-034 A shared package tbec_pkg SHALL hold:
- the state enum;
- the error-code constants ERR_NONE, ERR_CORR, ERR_UNCORR, ERR_RSVD;
- DATA_W and ADDR_W defaults.
REQ-035 A single sub-module, tbec_sat_cnt (a 16-bit saturating incrementer), SHALL be instantiated twice.

Verification
REQ-036 Reset, then scrub_en=1, interval=3, mem_err=00 always -> mem_addr advances by 1 every 3+RD_LAT+2 cycles, and mem_we never asserts.
REQ-037 mem_err=01 with mem_rd_data=16'hA5A5 at addr 8'h10 -> mem_we high exactly 2 cycles with mem_addr=8'h10, mem_data=16'hA5A5, and corr_cnt=1.
REQ-038 mem_err=10 at addr 8'h3C -> uncorr_cnt=1, last_uncorr_addr=8'h3C, no mem_we.
REQ-039 host_req raised during READ -> host_gnt rises only after NEXT, in the first WAIT cycle; host_req dropped -> host_gnt=0 one cycle later.
REQ-040 A full pass of 256 addresses -> one pass_done pulse on the 8'hFF to 8'h00 wrap; preloaded corr_cnt=16'hFFFF plus one more correction -> stays 16'hFFFF.
REQ-041 rst asserted in the first WRITE cycle -> mem_we=0 and all outputs at their reset values on the next cycle.
